// File: rtl/track_pkg.sv
// Shared constants for the scrolling three-lane ground track.
package track_pkg;

    // Screen y of each lane's ground line (bit k of lines/vid_lines -> LANE_Yk)
    localparam int LANE_Y0 = 120;
    localparam int LANE_Y1 = 240;
    localparam int LANE_Y2 = 360;

    localparam int SCREEN_W = 640;

    // 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right:
    // feedback is the XOR of bits 0, 2, 3 and 5, entering at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Column used when the random draw would leave every lane empty
    localparam logic [2:0] DEFAULT_COL = 3'b010;

    // Map a raw 3-bit draw to a column that always has some ground
    function automatic logic [2:0] map_column(input logic [2:0] raw);
        return (raw == 3'b000) ? DEFAULT_COL : raw;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step when adv is high.
module lfsr16
    import track_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    // Shift right, feeding the tap parity into the top bit
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst)      r_q <= LFSR_SEED;
        else if (adv) r_q <= {w_fb, r_q[15:1]};
    end

endmodule

// File: rtl/track_gen.sv
// Scrolling three-lane ground track generator.
// Optional macro TRACK_SPEEDUP_EN: shortens the scroll divider every
// 2**SPEED_LOG2 segment shifts, down to MIN_DIV.
module track_gen
    import track_pkg::*;
#(
    parameter int SEG_LOG2   = 5,
    parameter int NUM_SEGS   = 21,
    parameter int PLAYER_X   = 100,
    parameter int SCROLL_DIV = 250000,
    parameter int MIN_DIV    = 50000,
    parameter int SPEED_LOG2 = 4
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [9:0]  pixel_x,
    output logic [2:0]  lines,
    output logic [2:0]  vid_lines,
    output logic        seg_tick,
    output logic [15:0] seg_count
);

    localparam int                  DIV_W      = $clog2(SCROLL_DIV + 1);
    localparam logic [SEG_LOG2-1:0] OFF_MAX    = '1;
    localparam logic [10:0]         PLAYER_X_W = 11'(PLAYER_X);
    localparam logic [10:0]         NUM_SEGS_W = 11'(NUM_SEGS);

    logic [2:0][NUM_SEGS-1:0] r_lane;
    logic [SEG_LOG2-1:0]      r_offset;
    logic [DIV_W-1:0]         r_div_cnt;
    logic [15:0]              r_seg_count;
    logic                     r_seg_tick;
    logic [2:0]               r_lines;
    logic [2:0]               r_vid_lines;

    logic [DIV_W-1:0]         w_cur_div;
    logic                     w_step;
    logic                     w_shift;
    logic [15:0]              w_lfsr;
    logic [12:0]              w_lfsr_unused;
    logic [2:0]               w_col;
    logic [15:0]              w_seg_next;

    // A step fires on the last divider count; it becomes a shift when the
    // sub-segment offset is already at its maximum.
    assign w_step        = run && (r_div_cnt == w_cur_div - DIV_W'(1));
    assign w_shift       = w_step && (r_offset == OFF_MAX);
    assign w_col         = map_column(w_lfsr[2:0]);
    assign w_lfsr_unused = w_lfsr[15:3];
    assign w_seg_next    = r_seg_count + 16'd1;

    assign lines     = r_lines;
    assign vid_lines = r_vid_lines;
    assign seg_tick  = r_seg_tick;
    assign seg_count = r_seg_count;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (w_shift),
        .q   (w_lfsr)
    );

    // Ground bits at screen x: segment index is (x + offset) >> SEG_LOG2;
    // indices past the last segment read as empty.
    function automatic logic [2:0] lookup(
        input logic [10:0]              x,
        input logic [SEG_LOG2-1:0]      off,
        input logic [2:0][NUM_SEGS-1:0] lanes
    );
        logic [10:0]         idx;
        logic [NUM_SEGS-1:0] sel;
        logic [2:0]          res;
        idx = (x + 11'(off)) >> SEG_LOG2;
        res = '0;
        for (int k = 0; k < 3; k++) begin
            sel = lanes[k] >> idx;
            if (idx < NUM_SEGS_W) res[k] = sel[0];
        end
        return res;
    endfunction

`ifdef TRACK_SPEEDUP_EN
    logic [DIV_W-1:0] r_cur_div;

    // Shorten the divider on every 2**SPEED_LOG2-th shift. A decrement only
    // lands on a step edge, where div_cnt already returns to 0, so div_cnt
    // can never sit at or above the new cur_div.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cur_div <= DIV_W'(SCROLL_DIV);
        else if (w_shift && (w_seg_next[SPEED_LOG2-1:0] == '0) &&
                 (32'(r_cur_div) > MIN_DIV))
            r_cur_div <= r_cur_div - DIV_W'(1);
    end

    assign w_cur_div = r_cur_div;
`else
    logic [31:0] w_cfg_unused;

    // Fixed scroll rate; MIN_DIV and SPEED_LOG2 only matter with speed-up
    assign w_cur_div    = DIV_W'(SCROLL_DIV);
    assign w_cfg_unused = 32'(MIN_DIV) ^ 32'(SPEED_LOG2);
`endif

    // Divider, offset, lane shifting, distance count and registered lookups
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the lanes are plain flops with a defined power-up track,
            // so they are reset like any other state, unlike a RAM array.
            r_lane[0]   <= '0;
            r_lane[1]   <= '1;
            r_lane[2]   <= '0;
            r_offset    <= '0;
            r_div_cnt   <= '0;
            r_seg_count <= '0;
            r_seg_tick  <= 1'b0;
            r_lines     <= '0;
            r_vid_lines <= '0;
        end else begin
            r_lines     <= lookup(PLAYER_X_W, r_offset, r_lane);
            r_vid_lines <= lookup({1'b0, pixel_x}, r_offset, r_lane);
            r_seg_tick  <= w_shift;
            if (w_step) begin
                r_div_cnt <= '0;
                if (w_shift) begin
                    r_offset    <= '0;
                    r_seg_count <= w_seg_next;
                    for (int k = 0; k < 3; k++)
                        r_lane[k] <= {w_col[k], r_lane[k][NUM_SEGS-1:1]};
                end else begin
                    r_offset <= r_offset + 1'b1;
                end
            end else if (run) begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

endmodule
